// File: rtl/display_seq_pkg.sv
// Shared types and constants for the display sequencer.
// Configuration macro honoured by the slice: DISPLAY_SEQ_FIXED_PRIO_EN (see seq_arb2).
package display_seq_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StPlay} seq_state_t;

  localparam logic [6:0]  PLAY_CODE     = 7'h7F;
  localparam int unsigned CHAR_BIT      = 6;
  localparam int unsigned COLS_PER_CHAR = 8;
  localparam int unsigned RAW_COLS      = 1;

  // Display columns a word occupies in one rotation.
  function automatic logic [7:0] word_cols(input logic [6:0] word);
    return word[CHAR_BIT] ? 8'(COLS_PER_CHAR) : 8'(RAW_COLS);
  endfunction

endpackage

// File: rtl/seq_arb2.sv
// Two-requester arbiter: round-robin by default, fixed priority to requester 0
// when DISPLAY_SEQ_FIXED_PRIO_EN is defined (the pointer is then removed).
module seq_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

`ifdef DISPLAY_SEQ_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, accept};

  always_comb begin
    gnt = 2'b00;
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`else
  // High when requester 1 is favoured on a tie.
  logic prio_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (accept) begin
      prio_q <= gnt[0];
    end
  end
`endif

endmodule

// File: rtl/display_sequencer.sv
// Shares the display engine din bus between two message banks: load a bank's
// words, then play whole rotations. Honours DISPLAY_SEQ_FIXED_PRIO_EN via seq_arb2.
module display_sequencer
  import display_seq_pkg::*;
#(
  parameter int unsigned WORD_COUNT = 20,
  parameter int unsigned WORD_W     = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [3:0]        cfg_repeat,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [4:0]        wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_err,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic              busy,
  output logic [WORD_W-1:0] din_out
);

  logic [WORD_W-1:0] bank_q [2][WORD_COUNT];

  seq_state_t        state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [7:0]        rot_len_q, rot_len_d;
  logic [7:0]        rot_cnt_q, rot_cnt_d;
  logic [3:0]        rep_cnt_q, rep_cnt_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        done_q, done_d;
  logic              busy_q, busy_d;
  logic              wr_err_q, wr_err_d;
  logic [WORD_W-1:0] din_q, din_d;

  logic [1:0]        arb_gnt;
  logic              arb_accept;
  logic              bank_we;
  logic [WORD_W-1:0] wr_word;
  logic              rd_sel;
  logic [4:0]        rd_idx;
  logic [WORD_W-1:0] rd_word;

  seq_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (arb_accept),
    .gnt    (arb_gnt)
  );

  // The play code is never stored; the granted bank is locked against writes.
  always_comb begin
    wr_err_d = 1'b0;
    bank_we  = 1'b0;
    wr_word  = wr_data;
    if (wr_en && (wr_addr < 5'(WORD_COUNT))) begin
      if (grant_q[wr_sel]) begin
        wr_err_d = 1'b1;
      end else begin
        bank_we = 1'b1;
        if (wr_data == WORD_W'(PLAY_CODE)) begin
          wr_word  = '0;
          wr_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < int'(WORD_COUNT); w++) begin
          bank_q[b][w] <= '0;
        end
      end
    end else if (bank_we) begin
      bank_q[wr_sel][wr_addr] <= wr_word;
    end
  end

  assign rd_sel  = (state_q == StIdle) ? arb_gnt[1] : grant_q[1];
  assign rd_idx  = (state_q == StIdle) ? 5'd0 : idx_q;
  assign rd_word = bank_q[rd_sel][rd_idx];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rot_len_d  = rot_len_q;
    rot_cnt_d  = rot_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    grant_d    = grant_q;
    done_d     = 2'b00;
    din_d      = '0;
    arb_accept = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d    = StLoad;
          grant_d    = arb_gnt;
          arb_accept = 1'b1;
          din_d      = rd_word;
          rot_len_d  = word_cols(7'(rd_word));
          idx_d      = 5'd1;
          rep_cnt_d  = (cfg_repeat == 4'd0) ? 4'd1 : cfg_repeat;
        end
      end
      StLoad: begin
        if (idx_q == 5'(WORD_COUNT)) begin
          state_d   = StPlay;
          din_d     = WORD_W'(PLAY_CODE);
          rot_cnt_d = rot_len_q;
        end else begin
          din_d     = rd_word;
          rot_len_d = rot_len_q + word_cols(7'(rd_word));
          idx_d     = idx_q + 5'd1;
        end
      end
      StPlay: begin
        din_d = WORD_W'(PLAY_CODE);
        // Inner counter spans one rotation; outer counts rotations left.
        if (rot_cnt_q == 8'd1) begin
          if (rep_cnt_q == 4'd1) begin
            state_d = StIdle;
            din_d   = '0;
            done_d  = grant_q;
            grant_d = 2'b00;
          end else begin
            rot_cnt_d = rot_len_q;
            rep_cnt_d = rep_cnt_q - 4'd1;
          end
        end else begin
          rot_cnt_d = rot_cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      rot_len_q <= '0;
      rot_cnt_q <= '0;
      rep_cnt_q <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      wr_err_q  <= 1'b0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rot_len_q <= rot_len_d;
      rot_cnt_q <= rot_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      wr_err_q  <= wr_err_d;
      din_q     <= din_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign wr_err  = wr_err_q;
  assign din_out = din_q;

endmodule
